tpu_tile_sequencer: RTL and testbench

// Cycle-accurate controller that runs one matrix tile on the TPU datapath. It pops one weight
// set from the weight FIFO, pulses the array weight-reload, streams N input rows out of the

---
 rtl/tpu_tile_sequencer.sv | 123 ++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer: start/end_ handshaked controller for one TPU tile
// (weight pop, array reload, row streaming, result write-back tagging).
module tpu_tile_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int MATRIX_SIZE = 8,
    parameter int PIPE_LAT    = 2*MATRIX_SIZE+2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_in_base,
    input  logic [ADDRESSSIZE-1:0] cfg_out_base,
    input  logic [ADDRESSSIZE-1:0] cfg_num_rows,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_rd_addr,
    output logic                   res_valid,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   err,
    output logic                   end_
);
    typedef enum logic [2:0] {S_IDLE, S_POP, S_RELOAD, S_FEED, S_DRAIN, S_DONE} state_t;
    state_t                 r_state;
    logic [ADDRESSSIZE-1:0] r_in_base, r_out_base, r_num, r_row, r_res_cnt;
    logic [PIPE_LAT-1:0]    r_dly;
    logic [PIPE_LAT:0]      w_line;
    logic                   w_pre, w_last;
    // w_pre announces a result row one cycle ahead so res_addr rises together with res_valid
    assign w_line    = {r_dly, ub_rd_en};
    assign w_pre     = w_line[PIPE_LAT-1];
    assign w_last    = (r_res_cnt + ADDRESSSIZE'(w_pre)) == r_num;
    assign res_valid = r_dly[PIPE_LAT-1];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= S_IDLE;
            r_in_base        <= '0;
            r_out_base       <= '0;
            r_num            <= '0;
            r_row            <= '0;
            r_res_cnt        <= '0;
            r_dly            <= '0;
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            ub_rd_en         <= 1'b0;
            ub_rd_addr       <= '0;
            res_addr         <= '0;
            busy             <= 1'b0;
            err              <= 1'b0;
            end_             <= 1'b0;
        end else if (abort) begin
            r_state          <= S_IDLE;
            r_row            <= '0;
            r_res_cnt        <= '0;
            r_dly            <= '0;
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            ub_rd_en         <= 1'b0;
            busy             <= 1'b0;
            err              <= 1'b0;
            end_             <= 1'b0;
        end else begin
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            err              <= 1'b0;
            end_             <= 1'b0;
            r_dly            <= w_line[PIPE_LAT-1:0];
            if (w_pre) begin
                res_addr  <= r_out_base + r_res_cnt;
                r_res_cnt <= r_res_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start && cfg_num_rows == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b1;
                    end else if (start && fifo_empty) begin
                        err <= 1'b1;
                    end else if (start) begin
                        r_in_base        <= cfg_in_base;
                        r_out_base       <= cfg_out_base;
                        r_num            <= cfg_num_rows;
                        r_row            <= '0;
                        r_res_cnt        <= '0;
                        r_state          <= S_POP;
                        fifo_read_enable <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_RELOAD;
                    we_rl   <= 1'b1;
                end
                S_RELOAD: begin
                    r_state    <= S_FEED;
                    ub_rd_en   <= 1'b1;
                    ub_rd_addr <= r_in_base;
                    r_row      <= ADDRESSSIZE'(1);
                end
                S_FEED: begin
                    // r_row counts rows already issued; the last one may also finish the tile when PIPE_LAT=1
                    if (r_row == r_num) begin
                        ub_rd_en <= 1'b0;
                        r_state  <= w_last ? S_DONE : S_DRAIN;
                    end else begin
                        ub_rd_addr <= ub_rd_addr + 1'b1;
                        r_row      <= r_row + 1'b1;
                    end
                end
                S_DRAIN: if (w_last) r_state <= S_DONE;
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    end_    <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb_tpu_tile_sequencer: two DUTs (PIPE_LAT 18 and 2) on shared inputs, checked every cycle
// against a per-tile event schedule, plus table vectors and abort/reset sequences.
module tb_tpu_tile_sequencer;
    localparam int NC = 8192;
    logic clk = 0, rstn = 0, start = 0, abort = 0, fe = 0;
    logic [9:0] inb = '0, outb = '0, num = '0;
    logic [1:0] fre, we, rd, rv, busy, err, endp;
    logic [1:0][9:0] rda, ra;
    int cyc = 0, n_tests = 0, n_fail = 0;
    bit e_busy[2][NC], e_pop[2][NC], e_we[2][NC], e_rd[2][NC], e_rv[2][NC], e_err[2][NC], e_end[2][NC];
    logic [9:0] e_rda[2][NC], e_ra[2][NC];
    logic [9:0] lra[2];

    tpu_tile_sequencer #(.ADDRESSSIZE(10), .MATRIX_SIZE(8)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cfg_in_base(inb), .cfg_out_base(outb),
        .cfg_num_rows(num), .fifo_empty(fe), .fifo_read_enable(fre[0]), .we_rl(we[0]), .ub_rd_en(rd[0]),
        .ub_rd_addr(rda[0]), .res_valid(rv[0]), .res_addr(ra[0]), .busy(busy[0]), .err(err[0]), .end_(endp[0]));
    tpu_tile_sequencer #(.ADDRESSSIZE(10), .MATRIX_SIZE(8), .PIPE_LAT(2)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cfg_in_base(inb), .cfg_out_base(outb),
        .cfg_num_rows(num), .fifo_empty(fe), .fifo_read_enable(fre[1]), .we_rl(we[1]), .ub_rd_en(rd[1]),
        .ub_rd_addr(rda[1]), .res_valid(rv[1]), .res_addr(ra[1]), .busy(busy[1]), .err(err[1]), .end_(endp[1]));

    always #5 clk = ~clk;

    function automatic void chk(string nm, int d, logic [15:0] a, logic [15:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, a, e);
        end
    endfunction

    function automatic void clear_from(int d, int c);
        for (int k = c; k < c + 64 && k < NC; k++) begin
            e_busy[d][k] = 0; e_pop[d][k] = 0; e_we[d][k] = 0; e_rd[d][k] = 0;
            e_rv[d][k] = 0; e_err[d][k] = 0; e_end[d][k] = 0;
        end
    endfunction

    // A tile accepted at the end of cycle t lays out its whole event timeline in advance.
    function automatic void plan(int d, int t);
        int lat = (d == 1) ? 2 : 18;
        int n = int'(num);
        if (n == 0) begin
            e_busy[d][t+1] = 1;
            e_end[d][t+2] = 1;
        end else if (fe) begin
            e_err[d][t+1] = 1;
        end else begin
            e_pop[d][t+1] = 1;
            e_we[d][t+2] = 1;
            for (int c = t + 1; c <= t + 2 + n + lat; c++) e_busy[d][c] = 1;
            for (int i = 0; i < n; i++) begin
                e_rd[d][t+3+i] = 1;
                e_rda[d][t+3+i] = inb + 10'(i);
                e_rv[d][t+3+i+lat] = 1;
                e_ra[d][t+3+i+lat] = outb + 10'(i);
            end
            e_end[d][t+3+n+lat] = 1;
        end
    endfunction

    always @(posedge clk) begin : model
        int t;
        t = cyc;
        for (int d = 0; d < 2; d++)
            if (!rstn || abort) clear_from(d, t + 1);
            else if (start && !e_busy[d][t]) plan(d, t);
        cyc = t + 1;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                lra[d] = '0;
                chk("rst_strobes", d, {fre[d], we[d], rd[d], rv[d], busy[d], err[d], endp[d]}, 0);
                chk("rst_rd_addr", d, rda[d], 0);
                chk("rst_res_addr", d, ra[d], 0);
            end else begin
                chk("fifo_read_enable", d, fre[d], e_pop[d][cyc]);
                chk("we_rl", d, we[d], e_we[d][cyc]);
                chk("ub_rd_en", d, rd[d], e_rd[d][cyc]);
                chk("res_valid", d, rv[d], e_rv[d][cyc]);
                chk("busy", d, busy[d], e_busy[d][cyc]);
                chk("err", d, err[d], e_err[d][cyc]);
                chk("end_", d, endp[d], e_end[d][cyc]);
                if (e_rd[d][cyc]) chk("ub_rd_addr", d, rda[d], e_rda[d][cyc]);
                if (e_rv[d][cyc]) lra[d] = e_ra[d][cyc];
                chk("res_addr", d, ra[d], lra[d]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(int n, logic [9:0] ib, logic [9:0] ob, bit f);
        num = 10'(n); inb = ib; outb = ob; fe = f; start = 1;
    endtask

    // start one tile and measure it on the PIPE_LAT=18 instance over a fixed window
    task automatic run_one(int n, logic [9:0] ib, logic [9:0] ob, bit f, int x_lat, int x_err, int x_rd);
        int lat = 0, errs = 0, rds = 0;
        tick();
        go(n, ib, ob, f);
        tick();
        start = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (endp[0] && lat == 0) lat = k;
            if (err[0]) errs++;
            if (rd[0]) rds++;
        end
        chk("vec_end_latency", 0, 16'(lat), 16'(x_lat));
        chk("vec_err_pulses", 0, 16'(errs), 16'(x_err));
        chk("vec_rd_count", 0, 16'(rds), 16'(x_rd));
    endtask

    task automatic quiet_window(string nm);
        int q = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            q += int'(rd[0]) + int'(rv[0]) + int'(endp[0]) + int'(rd[1]) + int'(rv[1]) + int'(endp[1]);
        end
        chk(nm, 0, 16'(q), 0);
    endtask

    typedef struct {
        int n; logic [9:0] ib; logic [9:0] ob; bit f;
        int x_lat; int x_err; int x_rd;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{4, 10'h010, 10'h200, 1'b0, 25, 0, 4};
        vecs[1] = '{4, 10'h010, 10'h200, 1'b1, 0, 1, 0};
        vecs[2] = '{0, 10'h123, 10'h055, 1'b0, 2, 0, 0};
        vecs[3] = '{3, 10'h3FE, 10'h3FF, 1'b0, 24, 0, 3};
        vecs[4] = '{6, 10'h005, 10'h100, 1'b0, 27, 0, 6};
        vecs[5] = '{1, 10'h000, 10'h3FF, 1'b1 ^ 1'b1, 22, 0, 1};
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        foreach (vecs[i]) run_one(vecs[i].n, vecs[i].ib, vecs[i].ob, vecs[i].f, vecs[i].x_lat, vecs[i].x_err, vecs[i].x_rd);
        tick();
        go(8, 10'h040, 10'h080, 0);
        tick();
        start = 0;
        repeat (4) tick();
        abort = 1;
        tick();
        abort = 0;
        quiet_window("abort_quiet");
        run_one(4, 10'h010, 10'h200, 0, 25, 0, 4);
        tick();
        go(4, 10'h010, 10'h200, 0);
        tick();
        start = 0;
        repeat (11) tick();
        rstn = 0;
        repeat (2) tick();
        rstn = 1;
        quiet_window("reset_quiet");
        run_one(3, 10'h3FE, 10'h3FF, 0, 24, 0, 3);
        for (int k = 0; k < 3000; k++) begin
            tick();
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 99) == 0);
            fe    = ($urandom_range(0, 3) == 0);
            num   = 10'($urandom_range(0, 12));
            inb   = 10'($urandom);
            outb  = 10'($urandom);
        end
        start = 0;
        abort = 0;
        repeat (60) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
